// File: rtl/cpu_input_port_if.sv
// CPU-side read/status bundle of the input port.
// irq is present only when CPU_INPUT_PORT_IRQ_EN is defined.
`timescale 1ns/1ps
interface cpu_input_port_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [CW-1:0]     count;
    logic              full;
    logic              overflow;
    logic              ovf_clr;
`ifdef CPU_INPUT_PORT_IRQ_EN
    logic              irq;
`endif

    modport master (
        output rd_en, ovf_clr,
`ifdef CPU_INPUT_PORT_IRQ_EN
        input  irq,
`endif
        input  rd_data, rd_valid, count, full, overflow
    );

    modport slave (
        input  rd_en, ovf_clr,
`ifdef CPU_INPUT_PORT_IRQ_EN
        output irq,
`endif
        output rd_data, rd_valid, count, full, overflow
    );
endinterface

// File: rtl/cpu_input_port.sv
// Strobe-captured input FIFO feeding the CPU (show-ahead read).
// Macro CPU_INPUT_PORT_IRQ_EN adds a registered irq output.
`timescale 1ns/1ps
module cpu_input_port #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] input_pin,
    input  logic              input_enable,
    cpu_input_port_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   push;
    logic                   pop;
    logic                   wr;
    logic                   drop;
    logic                   full;
    logic                   valid;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   overflow;
    logic [DATA_W-1:0]      mem [DEPTH];

    // Edge detect after the synchroniser: one push per rising strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], input_enable};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign push  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign full  = (count == CW'(DEPTH));
    assign valid = (count != '0);
    assign pop   = bus.rd_en & valid;
    // A pop on the same edge frees the slot, so a full push still lands
    assign wr    = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= input_pin;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr && !pop)
                count <= count + CW'(1);
            else if (pop && !wr)
                count <= count - CW'(1);
            if (drop)
                overflow <= 1'b1;
            else if (bus.ovf_clr)
                overflow <= 1'b0;
        end
    end

`ifdef CPU_INPUT_PORT_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            irq_q <= 1'b0;
        else
            irq_q <= valid | overflow;
    end

    assign bus.irq = irq_q;
`endif

    assign bus.rd_data  = valid ? mem[rd_ptr] : '0;
    assign bus.rd_valid = valid;
    assign bus.count    = count;
    assign bus.full     = full;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_cpu_input_port.sv
// Directed self-checking bench for cpu_input_port.
// Define CPU_INPUT_PORT_IRQ_EN to include the irq scenario.
`timescale 1ns/1ps
module tb_cpu_input_port;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] input_pin = '0;
    logic        input_enable = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    cpu_input_port_if #(.DATA_W(16), .DEPTH(4)) bus ();

    cpu_input_port #(
        .DATA_W(16), .DEPTH(4), .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .input_pin(input_pin),
        .input_enable(input_enable),
        .bus(bus)
    );

    always #50 clk = ~clk;

    task automatic strobe(input logic [15:0] d);
        @(negedge clk);
        input_pin = d;
        input_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        input_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pop1();
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        bus.rd_en = 1'b0;
        bus.ovf_clr = 1'b0;
        #2 reset = 1'b0;
        #5;
        vectors++;
        if ({bus.rd_valid, bus.full, bus.overflow} !== 3'b000 ||
            bus.count !== 3'd0 || bus.rd_data !== 16'h0) begin
            miscompares++;
            $display("FAIL reset: valid=%b full=%b ovf=%b count=%0d data=%h, want all 0",
                     bus.rd_valid, bus.full, bus.overflow, bus.count, bus.rd_data);
        end
        reset = 1'b1;
    endtask

    task automatic test_first_capture();
        #(10000 - $time);
        input_pin = 16'hF0F0;
        input_enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL early_valid: got %b want 0", bus.rd_valid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'hF0F0 ||
            bus.count !== 3'd1) begin
            miscompares++;
            $display("FAIL first_capture: valid=%b data=%h count=%0d want 1 f0f0 1",
                     bus.rd_valid, bus.rd_data, bus.count);
        end
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (bus.count !== 3'd1) begin
            miscompares++;
            $display("FAIL held_level: count=%0d want 1", bus.count);
        end
        input_enable = 1'b0;
        repeat (2) @(posedge clk);
        pop1();
        vectors++;
        if (bus.count !== 3'd0 || bus.rd_data !== 16'h0) begin
            miscompares++;
            $display("FAIL drain1: count=%0d data=%h want 0 0", bus.count, bus.rd_data);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 4; i++) strobe(16'(i));
        vectors++;
        if (bus.full !== 1'b1 || bus.count !== 3'd4 || bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL fill: full=%b count=%0d ovf=%b want 1 4 0",
                     bus.full, bus.count, bus.overflow);
        end
        strobe(16'h0005);
        vectors++;
        if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin
            miscompares++;
            $display("FAIL drop: ovf=%b count=%0d want 1 4", bus.overflow, bus.count);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.rd_data !== 16'(i)) begin
                miscompares++;
                $display("FAIL fifo_order[%0d]: got %h want %h", i, bus.rd_data, 16'(i));
            end
            pop1();
        end
        vectors++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0 || bus.full !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_after_drain: valid=%b data=%h full=%b want 0 0 0",
                     bus.rd_valid, bus.rd_data, bus.full);
        end
        @(negedge clk);
        bus.ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.ovf_clr = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            strobe(16'hA000 + 16'(i));
            @(negedge clk);
            vectors++;
            if (bus.rd_data !== 16'hA000 + 16'(i) || bus.overflow !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap[%0d]: data=%h ovf=%b want %h 0",
                         i, bus.rd_data, bus.overflow, 16'hA000 + 16'(i));
            end
            pop1();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) strobe(16'hB000 + 16'(i));
        @(negedge clk);
        input_pin = 16'h1234;
        input_enable = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
        input_enable = 1'b0;
        vectors++;
        if (bus.count !== 3'd4 || bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL push_pop_full: count=%0d ovf=%b want 4 0",
                     bus.count, bus.overflow);
        end
        repeat (2) @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            logic [15:0] exp;
            exp = (i == 4) ? 16'h1234 : 16'hB000 + 16'(i);
            @(negedge clk);
            vectors++;
            if (bus.rd_data !== exp) begin
                miscompares++;
                $display("FAIL b2b_pop[%0d]: got %h want %h", i, bus.rd_data, exp);
            end
            pop1();
        end
    endtask

    task automatic test_ovf_clr_reset();
        for (int i = 0; i < 4; i++) strobe(16'hC000 + 16'(i));
        @(negedge clk);
        input_pin = 16'hDEAD;
        input_enable = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.ovf_clr = 1'b0;
        input_enable = 1'b0;
        vectors++;
        if (bus.overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL set_beats_clr: ovf=%b want 1", bus.overflow);
        end
        @(negedge clk);
        bus.ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.ovf_clr = 1'b0;
        vectors++;
        if (bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clr: ovf=%b want 0", bus.overflow);
        end
        pop1();
        vectors++;
        if (bus.count !== 3'd3 || bus.rd_data !== 16'hC001) begin
            miscompares++;
            $display("FAIL pre_reset: count=%0d data=%h want 3 c001", bus.count, bus.rd_data);
        end
        @(negedge clk);
        #10 reset = 1'b0;
        #1;
        vectors++;
        if (bus.count !== 3'd0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0) begin
            miscompares++;
            $display("FAIL async_reset: count=%0d valid=%b data=%h want 0 0 0",
                     bus.count, bus.rd_valid, bus.rd_data);
        end
        #5 reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

`ifdef CPU_INPUT_PORT_IRQ_EN
    task automatic test_irq();
        vectors++;
        if (bus.irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_idle: got %b want 0", bus.irq);
        end
        strobe(16'h0077);
        vectors++;
        if (bus.irq !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_set: got %b want 1", bus.irq);
        end
        pop1();
        vectors++;
        if (bus.irq !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_lag: got %b want 1", bus.irq);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_clear: got %b want 0", bus.irq);
        end
        for (int i = 0; i < 5; i++) strobe(16'hE000 + 16'(i));
        @(negedge clk);
        bus.ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.ovf_clr = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.irq !== 1'b1 || bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_ovf_held: irq=%b ovf=%b want 1 0", bus.irq, bus.overflow);
        end
        for (int i = 0; i < 4; i++) pop1();
        @(posedge clk);
        #1;
        vectors++;
        if (bus.irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_drained: got %b want 0", bus.irq);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_capture();
        test_fill_overflow();
        test_wrap();
        test_back_to_back();
        test_ovf_clr_reset();
`ifdef CPU_INPUT_PORT_IRQ_EN
        test_irq();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cpu_input_port.md
Name: cpu_input_port

Overview:
- Input-side peripheral that feeds the simple CPU's 16-bit input path.
- Samples the asynchronous board-level `input_pin` bus on each `input_enable` rising edge.
- Buffers captured words in a small FIFO and presents them to the CPU through a show-ahead read handshake.
- Sits directly upstream of the CPU core inside `top`, replacing a raw wire from `input_pin`.

Parameters:
- DATA_W, 16, width of the input word.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, flip-flop stages on `input_enable`; at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. 0 clears all state immediately; release is synchronous to clk.
- input_pin  input  DATA_W  external data bus, asynchronous to clk.
- input_enable  input  1  external strobe, asynchronous; a rising edge requests capture.
- rd_en  input  1  CPU pop request, sampled on clk.
- rd_data  output  DATA_W  head-of-FIFO word (show-ahead).
- rd_valid  output  1  FIFO non-empty.
- count  output  $clog2(DEPTH)+1  number of stored words.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag: a capture was dropped.
- ovf_clr  input  1  synchronous clear of `overflow`.
- irq  output  1  interrupt; exists only with CPU_INPUT_PORT_IRQ_EN.

Behaviour:
- **Reset (reset == 0):**
  - Pointers, count, sync chain, edge register, `overflow` and `irq` all go to 0.
  - `rd_data` = 0, `rd_valid` = 0, `full` = 0.
  - Memory contents are don't-care.
  - An assertion mid-operation discards all buffered words.
- **Strobe synchronisation:**
  - `input_enable` passes through SYNC_STAGES flops.
  - `push` is a one-cycle pulse when the synced value is 1 and the previous synced value was 0.
  - With the default 2 stages, `push` fires in the 3rd clk cycle after the rising edge.
  - A level held high produces only one push.
  - A strobe pulse shorter than one clk period may be missed; this is permitted.
- **Data capture:**
  - `input_pin` is written to `mem[wr_ptr]` on the clk edge where `push` == 1.
  - The external source holds `input_pin` stable from the `input_enable` rise until at least SYNC_STAGES+1 clk edges later.
- **FIFO storage:**
  - Circular buffer; pointers wrap modulo DEPTH.
  - `count` is a separate register; `full` and `rd_valid` are derived from it.
- **Read side:**
  - `rd_data` = `mem[rd_ptr]` when `rd_valid`, else 0, with combinational output from registered state.
  - A pop occurs on a clk edge with `rd_en` && `rd_valid`.
  - The next word (or 0) appears one cycle after the pop edge.
  - `rd_en` while empty is ignored; there is no error flag.
- **Write-side boundaries:**
  - push && !full: write; count+1.
  - push && full && !pop: word dropped; `overflow` <= 1; count unchanged.
- **Simultaneous push and pop:**
  - When full: both occur; count unchanged; the new word is accepted, with no overflow.
  - When empty: the pop is ignored and the push proceeds; count becomes 1.
- **Overflow flag:**
  - Set has priority over `ovf_clr` in the same cycle.
  - Otherwise `ovf_clr` clears it on the next edge.
- **Latency:**
  - `input_enable` rise to `rd_valid` = 1 takes SYNC_STAGES+1 clk edges; 3 cycles by default.
- **Throughput:** one capture per strobe; strobes must be separated by at least 2 clk cycles low.

Optional Feature:
- Macro: CPU_INPUT_PORT_IRQ_EN.
- **When defined:**
  - Port `irq` exists and is registered.
  - `irq` <= 1 on the edge after `count` goes from 0 to nonzero, or after `overflow` sets.
  - `irq` <= 0 on the edge after `count` returns to 0 and `overflow` == 0.
  - Reset value of `irq` is 0.
- **When undefined:**
  - The `irq` port and its logic are absent.
  - The CPU polls `rd_valid`.
  - All other behaviour is identical.

Test Plan:
1. **Reset and first capture:** clk period 100 ns; pulse reset low 5 ns → all outputs 0. Set `input_pin` = 16'hF0F0, raise `input_enable` at 10 µs → `rd_valid` = 1 and `rd_data` = 16'hF0F0 exactly 3 clk edges later; `count` = 1. Hold `input_enable` high → `count` stays 1.
2. **Fill and overflow:** 5 strobes with data 16'h0001 to 16'h0005, no reads → `full` = 1 after the 4th. 5th dropped: `overflow` = 1, `count` = 4. Four pops return 16'h0001 to 16'h0004 in order; then `rd_valid` = 0 and `rd_data` = 0.
3. **Wrap-around:** 10 strobe/pop pairs with data 16'hA000+i → every pop returns the matching word; pointers wrap twice; `overflow` stays 0.
4. **Simultaneous push and pop:** full FIFO, `rd_en` asserted on the push edge with data 16'h1234 → `count` stays 4, `overflow` = 0. 16'h1234 emerges as the 4th subsequent pop.
5. **Overflow clear and reset mid-operation:**
   - `ovf_clr` on the same edge as a dropped push → `overflow` stays 1.
   - `ovf_clr` alone → `overflow` = 0.
   - Reset asserted with `count` = 3 → `count`, `rd_valid` and `rd_data` go to 0 immediately, without waiting for a clk edge.
6. **IRQ (CPU_INPUT_PORT_IRQ_EN defined):**
   - One strobe → `irq` = 1 one cycle after `rd_valid` rises.
   - Pop to empty → `irq` = 0 on the following edge.
   - Overflow → `irq` = 1 until `ovf_clr` is applied and the FIFO is emptied.
